// File: rtl/ram_param_if.sv
// Bus bundle for ram_param: access/command inputs, registered read data,
// sweep status and the FSM state for observation.
interface ram_param_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] adr;
    logic [WIDTH-1:0]  data;
    logic              load;
    logic              rd_en;
    logic              clear;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              busy;
    logic              fsm_state;  // 1 = CLEAR sweep, 0 = IDLE

    // Handshake: load/rd_en/clear are single-cycle requests sampled on the
    // rising edge and only honoured while busy is low; out_valid pulses for
    // one cycle with out carrying the data of the read accepted on the previous edge.
    modport master (
        output adr, data, load, rd_en, clear,
        input  out, out_valid, busy, fsm_state
    );

    modport slave (
        input  adr, data, load, rd_en, clear,
        output out, out_valid, busy, fsm_state
    );
endinterface

// File: rtl/ram_param.sv
// Parametrised single-port RAM with registered reads and a clear sequencer
// that sweeps every word to CLEAR_VAL after reset and on command.
module ram_param #(
    parameter int                WIDTH     = 16,
    parameter int                ADDR_W    = 3,
    parameter logic [WIDTH-1:0]  CLEAR_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic              rd_go;
    logic [WIDTH-1:0]  out_q;
    logic              out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // The sweep owns the write port while busy; all bus requests are dropped.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        mem_we    = 1'b0;
        mem_wa    = bus.adr;
        mem_wd    = bus.data;
        rd_go     = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = ptr;
                mem_wd = CLEAR_VAL;
                if (&ptr) begin
                    ptr_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end else begin
                    mem_we = bus.load;
                    rd_go  = bus.rd_en;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Write-first: a read paired with a write returns the incoming data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_go;
            if (rd_go) begin
                out_q <= mem_we ? mem_wd : mem[bus.adr];
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state == ST_CLEAR);
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: two instances (16x8 clearing to 0, 8x16 clearing to 5A)
// driven from a vector table plus hand-written clear/reset sequences.
module tb_ram_param;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    ram_param_if #(.WIDTH(16), .ADDR_W(3)) ia ();
    ram_param_if #(.WIDTH(8),  .ADDR_W(4)) ib ();

    ram_param #(.WIDTH(16), .ADDR_W(3), .CLEAR_VAL(16'h0000)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (ia.slave)
    );

    ram_param #(.WIDTH(8), .ADDR_W(4), .CLEAR_VAL(8'h5A)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (ib.slave)
    );

    typedef struct {
        logic        ld;
        logic        rd;
        logic [3:0]  adr;
        logic [15:0] data;
        logic [15:0] rexp;
    } vec_t;

    vec_t        tbl_a[$];
    vec_t        tbl_b[$];
    logic [15:0] exp_q[$];
    logic [15:0] last_out;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic rd, input logic [3:0] a,
                                input logic [15:0] d, input logic [15:0] rexp);
        vec_t v;
        v.ld = ld; v.rd = rd; v.adr = a; v.data = d; v.rexp = rexp;
        return v;
    endfunction

    task automatic drive(input bit sel, input logic ld, input logic rd, input logic clr,
                         input logic [3:0] a, input logic [15:0] d);
        if (!sel) begin
            ia.load = ld; ia.rd_en = rd; ia.clear = clr; ia.adr = a[2:0]; ia.data = d;
        end else begin
            ib.load = ld; ib.rd_en = rd; ib.clear = clr; ib.adr = a; ib.data = d[7:0];
        end
    endtask

    task automatic get(input bit sel, output logic [15:0] o, output logic v, output logic b);
        if (!sel) begin
            o = ia.out; v = ia.out_valid; b = ia.busy;
        end else begin
            o = {8'h00, ib.out}; v = ib.out_valid; b = ib.busy;
        end
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic step(input bit sel, input logic ld, input logic rd, input logic clr,
                        input logic [3:0] a, input logic [15:0] d, input logic [15:0] rexp,
                        input logic vexp, input logic bexp, input string nm);
        logic [15:0] o, e;
        logic        v, b;
        drive(sel, ld, rd, clr, a, d);
        if (vexp) exp_q.push_back(rexp);
        @(posedge clk);
        @(negedge clk);
        get(sel, o, v, b);
        chk({nm, "_busy"}, {31'd0, b}, {31'd0, bexp});
        chk({nm, "_valid"}, {31'd0, v}, {31'd0, vexp});
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({nm, "_out"}, {16'd0, o}, {16'd0, e});
            last_out = e;
        end else begin
            chk({nm, "_hold"}, {16'd0, o}, {16'd0, last_out});
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    endtask

    // Random requests while busy must be dropped; counts edges until busy falls.
    task automatic wait_idle(input bit sel, input string nm, input int exp_n);
        int          n    = 0;
        bit          done = 1'b0;
        logic [15:0] o;
        logic        v, b;
        while (!done && n < 64) begin
            drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
            @(posedge clk);
            @(negedge clk);
            n++;
            get(sel, o, v, b);
            chk({nm, "_drop_valid"}, {31'd0, v}, 32'd0);
            chk({nm, "_drop_out"}, {16'd0, o}, {16'd0, last_out});
            if (!b) done = 1'b1;
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        chk({nm, "_busy_edges"}, n, exp_n);
    endtask

    task automatic reset_check(input bit sel, input string nm, input logic [15:0] clr_val);
        logic [15:0] o;
        logic        v, b;
        get(sel, o, v, b);
        chk({nm, "_rst_out"}, {16'd0, o}, 32'd0);
        chk({nm, "_rst_valid"}, {31'd0, v}, 32'd0);
        chk({nm, "_rst_busy"}, {31'd0, b}, 32'd1);
        chk({nm, "_rst_fsm"}, {31'd0, sel ? ib.fsm_state : ia.fsm_state}, 32'd1);
        last_out = 16'd0;
        exp_q.delete();
        if (clr_val != 16'd0) last_out = 16'd0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);

        // Vector tables for the idle-state behaviour of each instance.
        for (int i = 0; i < 8; i++) tbl_a.push_back(mk(1'b0, 1'b1, 4'(i), 16'd0, 16'h0000));
        tbl_a.push_back(mk(1'b1, 1'b0, 4'd0, 16'h1234, 16'd0));
        tbl_a.push_back(mk(1'b1, 1'b0, 4'd1, 16'h5678, 16'd0));
        tbl_a.push_back(mk(1'b0, 1'b1, 4'd0, 16'd0, 16'h1234));
        tbl_a.push_back(mk(1'b0, 1'b1, 4'd1, 16'd0, 16'h5678));
        tbl_a.push_back(mk(1'b0, 1'b0, 4'd0, 16'd0, 16'd0));
        tbl_a.push_back(mk(1'b0, 1'b0, 4'd3, 16'h9999, 16'd0));
        tbl_a.push_back(mk(1'b1, 1'b1, 4'd5, 16'hBEEF, 16'hBEEF));
        tbl_a.push_back(mk(1'b0, 1'b1, 4'd5, 16'd0, 16'hBEEF));
        tbl_a.push_back(mk(1'b1, 1'b1, 4'd6, 16'h0606, 16'h0606));
        tbl_a.push_back(mk(1'b0, 1'b1, 4'd0, 16'd0, 16'h1234));
        for (int i = 0; i < 8; i++) tbl_a.push_back(mk(1'b1, 1'b0, 4'(i), 16'hA100 + 16'(i), 16'd0));
        tbl_a.push_back(mk(1'b0, 1'b1, 4'd7, 16'd0, 16'hA107));
        tbl_a.push_back(mk(1'b0, 1'b1, 4'd2, 16'd0, 16'hA102));

        for (int i = 0; i < 16; i++) tbl_b.push_back(mk(1'b0, 1'b1, 4'(i), 16'd0, 16'h005A));
        tbl_b.push_back(mk(1'b1, 1'b0, 4'd15, 16'h00C3, 16'd0));
        tbl_b.push_back(mk(1'b0, 1'b1, 4'd15, 16'd0, 16'h00C3));
        tbl_b.push_back(mk(1'b1, 1'b1, 4'd9, 16'h0011, 16'h0011));
        tbl_b.push_back(mk(1'b0, 1'b1, 4'd14, 16'd0, 16'h005A));
        tbl_b.push_back(mk(1'b0, 1'b1, 4'd9, 16'd0, 16'h0011));

        // Instance A: reset state, power-up sweep, idle vectors.
        repeat (3) @(negedge clk);
        reset_check(1'b0, "a", 16'h0000);
        rst_a = 1'b1;
        wait_idle(1'b0, "a_init", 8);
        foreach (tbl_a[i])
            step(1'b0, tbl_a[i].ld, tbl_a[i].rd, 1'b0, tbl_a[i].adr, tbl_a[i].data,
                 tbl_a[i].rexp, tbl_a[i].rd, 1'b0, $sformatf("a_vec%0d", i));

        // Clear with a simultaneous load: the load must not land.
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'hAAAA, 16'd0, 1'b0, 1'b1, "a_clr");
        wait_idle(1'b0, "a_clr", 8);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 16'd0, 16'h0000, 1'b1, 1'b0,
                 $sformatf("a_post_clr%0d", i));

        // Reset in the middle of a sweep with non-zero out.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'h1111, 16'd0, 1'b0, 1'b0, "a_ld3");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'd0, 16'h1111, 1'b1, 1'b0, "a_rd3");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0, 16'd0, 1'b0, 1'b1, "a_clr2");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b1, $sformatf("a_sweep%0d", i));
        rst_a = 1'b0;
        #1;
        reset_check(1'b0, "a_mid", 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        wait_idle(1'b0, "a_restart", 8);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'd0, 16'h0000, 1'b1, 1'b0, "a_rd3_after");

        // Instance B: wider address, narrower data, non-zero clear value.
        reset_check(1'b1, "b", 16'h005A);
        rst_b = 1'b1;
        wait_idle(1'b1, "b_init", 16);
        foreach (tbl_b[i])
            step(1'b1, tbl_b[i].ld, tbl_b[i].rd, 1'b0, tbl_b[i].adr, tbl_b[i].data,
                 tbl_b[i].rexp, tbl_b[i].rd, 1'b0, $sformatf("b_vec%0d", i));
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0, 16'd0, 1'b0, 1'b1, "b_clr");
        wait_idle(1'b1, "b_clr", 16);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 16'd0, 16'h005A, 1'b1, 1'b0, "b_rd15_clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
Parametrised synchronous single-port RAM, the successor to the fixed 8x16 ram8. Width and depth are generic. Reads are registered and flagged with a valid strobe. A built-in clear sequencer sweeps every word to a constant, both after reset and on command, and reports busy while it runs. It is the general storage primitive for the memory hierarchy, replacing ram8/ram64-style fixed blocks.

Parameters:
WIDTH, 16, data word width in bits (>=1)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words
CLEAR_VAL, 0, WIDTH-bit value written to every word by the clear sweep

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
adr  input  ADDR_W  word address for load and rd_en
data  input  WIDTH  write data
load  input  1  write data to mem[adr] at the clock edge (ignored while busy)
rd_en  input  1  read request for mem[adr] (ignored while busy)
clear  input  1  start a clear sweep (accepted only in IDLE)
out  output  WIDTH  registered read data; holds its value between reads
out_valid  output  1  high for exactly one cycle after an accepted read
busy  output  1  high while the clear sweep runs

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out=0, out_valid=0, busy=1.
  - FSM=CLEAR, sweep pointer ptr=0.
  - Memory array is not reset directly. The sweep initialises it.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each edge writes CLEAR_VAL to mem[ptr], then ptr increments.
  - On the edge where ptr==DEPTH-1: final write, ptr returns to 0, FSM goes to IDLE.
  - Sweep lasts exactly DEPTH edges. busy = (FSM==CLEAR), driven from the state register.
  - After rst_n rises, busy falls after the DEPTH-th rising edge.
- While busy:
  - load, rd_en and clear are dropped, not queued.
  - out holds its value; out_valid=0.
- IDLE, on each edge:
  - clear=1: FSM goes to CLEAR with ptr=0, busy=1 next cycle. Any load/rd_en in the same cycle is dropped (clear has priority).
  - Otherwise load=1: mem[adr] <= data.
  - Otherwise-independent rd_en=1: out <= mem[adr] and out_valid <= 1. Read latency is 1 cycle.
  - rd_en=0: out_valid <= 0 and out holds.
  - load and rd_en together at the same adr: write-first, so out <= data (the new value).
  - load and rd_en together at different addresses: both take effect.
- Address range is full, so no out-of-range case exists.
- ptr wrap is DEPTH-1 -> 0; no overflow state.
- Reset mid-sweep or mid-access: asynchronous return to the reset state, and the sweep restarts from word 0 after release.
- out is unaffected by the sweep itself. A read after the sweep returns CLEAR_VAL.

Test Plan:
- WIDTH=16, ADDR_W=3. Release reset, sample busy each edge -> busy=1 for exactly 8 edges, then 0. rd_en at adr 0..7 -> out=0x0000 with out_valid one cycle after each request.
- In IDLE: load adr=0 data=0x1234, then load adr=1 data=0x5678, then rd_en adr=0 -> out=0x1234 one cycle later. rd_en adr=1 -> out=0x5678. out holds 0x5678 with out_valid=0 afterwards.
- load=1 and rd_en=1 at adr=5 with data=0xBEEF in the same cycle -> next cycle out=0xBEEF, out_valid=1. A later read of adr=5 -> 0xBEEF.
- Fill all 8 words with nonzero data, pulse clear together with load adr=2 data=0xAAAA:
  - busy=1 for 8 cycles.
  - load/rd_en issued during busy are dropped: out unchanged, out_valid=0, no memory change.
  - Then all reads -> 0x0000 (the load in the clear cycle did not land).
- Assert rst_n=0 for one cycle at sweep edge 4 -> outputs go to reset values immediately (out=0, out_valid=0, busy=1). After release, busy=1 for a full 8 edges.
- Re-run with WIDTH=8, ADDR_W=4, CLEAR_VAL=8'h5A:
  - busy lasts 16 edges.
  - All reads return 0x5A until written.
  - Write/read adr=15 with 0xC3 -> 0xC3.
